// File: rtl/knight_pkg.sv
// Shared types and constants for the knight's tour move sequencer.
package knight_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VERT   = 3'd1,
    ST_HOLD_V = 3'd2,
    ST_HORZ   = 3'd3,
    ST_HOLD_H = 3'd4
  } state_t;

  localparam logic [3:0] OP_MOVE     = 4'h2;
  localparam logic [3:0] OP_MOVE_FAN = 4'h3;
  localparam logic [3:0] OP_ABORT    = 4'hF;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_MID = 8'h5A;

endpackage

// File: rtl/knight_move_decode.sv
// Splits a one-hot knight move into a vertical leg and a horizontal leg.
// Multiple set bits resolve to the lowest one; an all-zero move is flagged invalid.
module knight_move_decode
  import knight_pkg::*;
(
  input  logic [7:0] move,
  output logic [7:0] vert_heading,
  output logic [3:0] vert_sq,
  output logic [7:0] horz_heading,
  output logic [3:0] horz_sq,
  output logic       valid
);

  always_comb begin
    vert_heading = HDG_N;
    vert_sq      = 4'd0;
    horz_heading = HDG_N;
    horz_sq      = 4'd0;
    valid        = |move;
    // bit order: (+1,+2) (-1,+2) (-2,+1) (-2,-1) (-1,-2) (+1,-2) (+2,-1) (+2,+1)
    casez (move)
      8'b???????1: begin vert_heading = HDG_N; vert_sq = 4'd2; horz_heading = HDG_E; horz_sq = 4'd1; end
      8'b??????10: begin vert_heading = HDG_N; vert_sq = 4'd2; horz_heading = HDG_W; horz_sq = 4'd1; end
      8'b?????100: begin vert_heading = HDG_N; vert_sq = 4'd1; horz_heading = HDG_W; horz_sq = 4'd2; end
      8'b????1000: begin vert_heading = HDG_S; vert_sq = 4'd1; horz_heading = HDG_W; horz_sq = 4'd2; end
      8'b???10000: begin vert_heading = HDG_S; vert_sq = 4'd2; horz_heading = HDG_W; horz_sq = 4'd1; end
      8'b??100000: begin vert_heading = HDG_S; vert_sq = 4'd2; horz_heading = HDG_E; horz_sq = 4'd1; end
      8'b?1000000: begin vert_heading = HDG_S; vert_sq = 4'd1; horz_heading = HDG_E; horz_sq = 4'd2; end
      8'b10000000: begin vert_heading = HDG_N; vert_sq = 4'd1; horz_heading = HDG_E; horz_sq = 4'd2; end
      default: ;
    endcase
  end

endmodule

// File: rtl/knight_move_sequencer.sv
// Knight's tour sequencer and cmd_proc command mux (UART passthrough when idle).
// Optional KNIGHT_TOUR_ABORT_EN: a UART abort opcode returns the sequencer to IDLE mid-tour.
//
// state     | meaning
// ----------+----------------------------------------------------
// ST_IDLE   | UART commands passed straight through to cmd_proc
// ST_VERT   | vertical leg command offered, waiting for clr_cmd_rdy
// ST_HOLD_V | vertical leg in progress, waiting for send_resp
// ST_HORZ   | horizontal leg (with fanfare) offered
// ST_HOLD_H | horizontal leg in progress; advance or finish tour
module knight_move_sequencer
  import knight_pkg::*;
#(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic [7:0]  resp
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  state_t     state, state_nxt;
  logic       clr_idx, inc_idx;
  logic       abort_req;
  logic       last_move;
  logic [7:0] vert_heading, horz_heading;
  logic [3:0] vert_sq, horz_sq;
  logic       move_valid;

  knight_move_decode u_decode (
    .move         (move),
    .vert_heading (vert_heading),
    .vert_sq      (vert_sq),
    .horz_heading (horz_heading),
    .horz_sq      (horz_sq),
    .valid        (move_valid)
  );

`ifdef KNIGHT_TOUR_ABORT_EN
  assign abort_req = cmd_rdy_UART && (cmd_UART[15:12] == OP_ABORT);
`else
  assign abort_req = 1'b0;
`endif

  assign last_move = (mv_indx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       mv_indx <= 5'd0;
    else if (clr_idx) mv_indx <= 5'd0;
    else if (inc_idx) mv_indx <= mv_indx + 5'd1;
  end

  always_comb begin
    state_nxt = state;
    clr_idx   = 1'b0;
    inc_idx   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_tour) begin
          state_nxt = ST_VERT;
          clr_idx   = 1'b1;
        end
      end
      ST_VERT: begin
        if (!move_valid)      state_nxt = ST_IDLE;
        else if (clr_cmd_rdy) state_nxt = ST_HOLD_V;
      end
      ST_HOLD_V: if (send_resp)   state_nxt = ST_HORZ;
      ST_HORZ:   if (clr_cmd_rdy) state_nxt = ST_HOLD_H;
      ST_HOLD_H: begin
        if (send_resp) begin
          if (last_move) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_VERT;
            inc_idx   = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Abort wins over any in-flight leg; the abort command itself then flows through the IDLE mux.
    if ((state != ST_IDLE) && abort_req) begin
      state_nxt = ST_IDLE;
      clr_idx   = 1'b1;
      inc_idx   = 1'b0;
    end
  end

  always_comb begin
    cmd     = cmd_UART;
    cmd_rdy = cmd_rdy_UART;
    resp    = RESP_MID;
    case (state)
      ST_IDLE: resp = RESP_ACK;
      ST_VERT: begin
        cmd     = {OP_MOVE, vert_heading, vert_sq};
        cmd_rdy = move_valid;
      end
      ST_HOLD_V: begin
        cmd     = {OP_MOVE, vert_heading, vert_sq};
        cmd_rdy = 1'b0;
      end
      ST_HORZ: begin
        cmd     = {OP_MOVE_FAN, horz_heading, horz_sq};
        cmd_rdy = 1'b1;
      end
      ST_HOLD_H: begin
        cmd     = {OP_MOVE_FAN, horz_heading, horz_sq};
        cmd_rdy = 1'b0;
        resp    = last_move ? RESP_ACK : RESP_MID;
      end
      default: resp = RESP_ACK;
    endcase
  end

endmodule

// File: tb/tb_knight_move_sequencer.sv
// Directed bench for knight_move_sequencer: decode table, full tour, reset and abort corners.
// Checks the KNIGHT_TOUR_ABORT_EN behaviour matching however the design is compiled.
module tb_knight_move_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic [7:0]  resp;

  logic        use_mem;
  logic [7:0]  move_force;
  logic [7:0]  tour_mem [0:23];

  int n_cmp = 0;
  int n_err = 0;
  int n_cmds;

  int dx_t [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int dy_t [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  typedef struct {
    logic [7:0]  mv;
    logic [15:0] exp_v;
    logic [15:0] exp_h;
  } vec_t;
  vec_t vecs [11];

  knight_move_sequencer #(.NUM_MOVES(24)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_tour   (start_tour),
    .move         (move),
    .mv_indx      (mv_indx),
    .cmd_UART     (cmd_UART),
    .cmd_rdy_UART (cmd_rdy_UART),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .resp         (resp)
  );

  always #5 clk = ~clk;

  always_comb begin
    move = move_force;
    if (use_mem) move = (mv_indx < 5'd24) ? tour_mem[mv_indx] : 8'h00;
  end

  function automatic logic [15:0] exp_cmd(input logic [7:0] m, input bit horz);
    int b;
    int dx;
    int dy;
    b = -1;
    for (int i = 7; i >= 0; i--) if (m[i]) b = i;
    if (b < 0) return 16'h0000;
    dx = dx_t[b];
    dy = dy_t[b];
    if (horz) return {4'h3, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx < 0) ? -dx : dx)};
    return {4'h2, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy < 0) ? -dy : dy)};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1; cyc(); clr_cmd_rdy = 1'b0; #1;
  endtask

  task automatic pulse_send();
    send_resp = 1'b1; cyc(); send_resp = 1'b0; #1;
  endtask

  task automatic pulse_start();
    start_tour = 1'b1; cyc(); start_tour = 1'b0; #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cyc(); rst_n = 1'b1; #1;
  endtask

  task automatic wait_rdy(input string what);
    int k;
    k = 0;
    while (!cmd_rdy && k < 20) begin
      cyc(); #1;
      k++;
    end
    if (!cmd_rdy) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: cmd_rdy timeout got 0 expected 1", what);
    end
  endtask

  initial begin
    vecs[0]  = '{8'h01, 16'h2002, 16'h3BF1};
    vecs[1]  = '{8'h02, 16'h2002, 16'h33F1};
    vecs[2]  = '{8'h04, 16'h2001, 16'h33F2};
    vecs[3]  = '{8'h08, 16'h27F1, 16'h33F2};
    vecs[4]  = '{8'h10, 16'h27F2, 16'h33F1};
    vecs[5]  = '{8'h20, 16'h27F2, 16'h3BF1};
    vecs[6]  = '{8'h40, 16'h27F1, 16'h3BF2};
    vecs[7]  = '{8'h80, 16'h2001, 16'h3BF2};
    vecs[8]  = '{8'h0C, 16'h2001, 16'h33F2};
    vecs[9]  = '{8'hFF, 16'h2002, 16'h3BF1};
    vecs[10] = '{8'hA0, 16'h27F2, 16'h3BF1};
    for (int i = 0; i < 24; i++) tour_mem[i] = 8'(1 << ((i * 3) % 8));

    rst_n = 1'b0; start_tour = 1'b0; cmd_UART = 16'h0000; cmd_rdy_UART = 1'b0;
    clr_cmd_rdy = 1'b0; send_resp = 1'b0; use_mem = 1'b0; move_force = 8'h01;
    cyc(); cyc();
    rst_n = 1'b1; #1;

    // idle passthrough
    chk("rst_mv_indx", {11'd0, mv_indx}, 16'd0);
    chk("rst_resp", {8'd0, resp}, 16'h00A5);
    chk("idle_rdy_low", {15'd0, cmd_rdy}, 16'd0);
    cmd_UART = 16'h2004; cmd_rdy_UART = 1'b1; #1;
    chk("idle_cmd", cmd, 16'h2004);
    chk("idle_rdy", {15'd0, cmd_rdy}, 16'd1);
    cmd_rdy_UART = 1'b0; #1;

    // decode table applied as consecutive moves of one tour
    move_force = vecs[0].mv;
    pulse_start();
    for (int i = 0; i < 11; i++) begin
      move_force = vecs[i].mv; #1;
      chk($sformatf("v%0d_vcmd", i), cmd, vecs[i].exp_v);
      chk($sformatf("v%0d_vrdy", i), {15'd0, cmd_rdy}, 16'd1);
      chk($sformatf("v%0d_idx", i), {11'd0, mv_indx}, 16'(i));
      pulse_clr();
      chk($sformatf("v%0d_holdv_rdy", i), {15'd0, cmd_rdy}, 16'd0);
      pulse_send();
      chk($sformatf("v%0d_hcmd", i), cmd, vecs[i].exp_h);
      chk($sformatf("v%0d_hrdy", i), {15'd0, cmd_rdy}, 16'd1);
      pulse_clr();
      chk($sformatf("v%0d_resp", i), {8'd0, resp}, 16'h005A);
      pulse_send();
    end
    do_reset();

    // zero move: no command, back to idle
    move_force = 8'h00;
    pulse_start();
    chk("zero_rdy", {15'd0, cmd_rdy}, 16'd0);
    cyc();
    cmd_UART = 16'h2004; cmd_rdy_UART = 1'b1; #1;
    chk("zero_idle_cmd", cmd, 16'h2004);
    chk("zero_idle_rdy", {15'd0, cmd_rdy}, 16'd1);
    cmd_rdy_UART = 1'b0; #1;

    // ignored inputs and same-cycle clr/send in VERT
    move_force = 8'h04;
    pulse_start();
    pulse_send();
    chk("vert_send_ign_rdy", {15'd0, cmd_rdy}, 16'd1);
    chk("vert_send_ign_cmd", cmd, 16'h2001);
    clr_cmd_rdy = 1'b1; send_resp = 1'b1; cyc(); clr_cmd_rdy = 1'b0; send_resp = 1'b0; #1;
    chk("clr_send_rdy", {15'd0, cmd_rdy}, 16'd0);
    cyc(); #1;
    chk("clr_send_holdv", {15'd0, cmd_rdy}, 16'd0);
    pulse_start();
    chk("holdv_start_rdy", {15'd0, cmd_rdy}, 16'd0);
    chk("holdv_start_idx", {11'd0, mv_indx}, 16'd0);
    pulse_clr();
    chk("holdv_clr_ign", {15'd0, cmd_rdy}, 16'd0);
    pulse_send();
    chk("horz_cmd_0c", cmd, 16'h33F2);
    chk("horz_rdy_0c", {15'd0, cmd_rdy}, 16'd1);

    // UART abort during HORZ
    cmd_UART = 16'hF000; cmd_rdy_UART = 1'b1;
    cyc(); #1;
`ifdef KNIGHT_TOUR_ABORT_EN
    chk("abort_cmd", cmd, 16'hF000);
    chk("abort_rdy", {15'd0, cmd_rdy}, 16'd1);
    chk("abort_idx", {11'd0, mv_indx}, 16'd0);
    cmd_rdy_UART = 1'b0;
`else
    chk("noabort_cmd", cmd, 16'h33F2);
    chk("noabort_rdy", {15'd0, cmd_rdy}, 16'd1);
    cmd_rdy_UART = 1'b0;
    pulse_clr();
    pulse_send();
    chk("noabort_idx", {11'd0, mv_indx}, 16'd1);
    chk("noabort_next", cmd, 16'h2001);
`endif
    do_reset();

    // full 24-move tour from move memory
    use_mem = 1'b1;
    n_cmds = 0;
    pulse_start();
    for (int i = 0; i < 24; i++) begin
      wait_rdy("tour_v");
      if (cmd_rdy) n_cmds++;
      chk($sformatf("tour%0d_v", i), cmd, exp_cmd(tour_mem[i], 1'b0));
      chk($sformatf("tour%0d_idx", i), {11'd0, mv_indx}, 16'(i));
      pulse_clr();
      pulse_send();
      wait_rdy("tour_h");
      if (cmd_rdy) n_cmds++;
      chk($sformatf("tour%0d_h", i), cmd, exp_cmd(tour_mem[i], 1'b1));
      pulse_clr();
      chk($sformatf("tour%0d_resp", i), {8'd0, resp}, (i == 23) ? 16'h00A5 : 16'h005A);
      pulse_send();
    end
    chk("tour_cmd_count", 16'(n_cmds), 16'd48);
    cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1; #1;
    chk("tour_end_cmd", cmd, 16'h1234);
    chk("tour_end_rdy", {15'd0, cmd_rdy}, 16'd1);
    chk("tour_end_resp", {8'd0, resp}, 16'h00A5);
    cmd_rdy_UART = 1'b0; #1;

    // reset in HOLD_H at index 7
    use_mem = 1'b0; move_force = 8'h01;
    pulse_start();
    for (int k = 0; k < 7; k++) begin
      pulse_clr(); pulse_send(); pulse_clr(); pulse_send();
    end
    pulse_clr(); pulse_send(); pulse_clr();
    chk("hold7_idx", {11'd0, mv_indx}, 16'd7);
    chk("hold7_rdy", {15'd0, cmd_rdy}, 16'd0);
    do_reset();
    cmd_UART = 16'h2004; cmd_rdy_UART = 1'b1; #1;
    chk("midrst_idx", {11'd0, mv_indx}, 16'd0);
    chk("midrst_cmd", cmd, 16'h2004);
    chk("midrst_rdy", {15'd0, cmd_rdy}, 16'd1);
    chk("midrst_resp", {8'd0, resp}, 16'h00A5);
    cmd_rdy_UART = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/knight_move_sequencer.md
# knight_move_sequencer

Sequences a solved Knight's Tour into drive commands for `cmd_proc`. It sits between the UART command wrapper, the tour-solver move memory and `cmd_proc`, and also acts as the command-path mux. In IDLE it passes UART commands straight through to `cmd_proc`. After `start_tour` it takes over the command path and splits each stored one-hot knight move into two orthogonal legs: a vertical move, then a horizontal move with fanfare. It waits for move completion before issuing the next leg.

## Interface
Parameters:
- `NUM_MOVES`, default 24: number of moves in the solved tour (5x5 board).

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: synchronous, active-low reset.
- `start_tour`  in  1: one-cycle pulse from solver; starts sequencing at index 0.
- `move`  in  8: one-hot move read from solver memory at `mv_indx`.
- `mv_indx`  out  5: index into solver move memory.
- `cmd_UART`  in  16: command from UART wrapper.
- `cmd_rdy_UART`  in  1: UART command valid.
- `clr_cmd_rdy`  in  1: `cmd_proc` has consumed `cmd`.
- `send_resp`  in  1: `cmd_proc` pulse; current move complete.
- `cmd`  out  16: command to `cmd_proc`.
- `cmd_rdy`  out  1: `cmd` valid.
- `resp`  out  8: response byte returned with each `send_resp`.

## Operation
- States: IDLE, VERT, HOLD_V, HORZ, HOLD_H.
- IDLE:
  - `cmd` = `cmd_UART`, `cmd_rdy` = `cmd_rdy_UART`.
  - `start_tour` -> VERT, `mv_indx` <= 0.
- VERT:
  - `cmd` = {4'h2, vert_heading, vert_sq}, `cmd_rdy` = 1.
  - `clr_cmd_rdy` -> HOLD_V.
- HOLD_V:
  - `cmd_rdy` = 0.
  - `send_resp` -> HORZ.
- HORZ:
  - `cmd` = {4'h3, horz_heading, horz_sq}, `cmd_rdy` = 1.
  - `clr_cmd_rdy` -> HOLD_H.
- HOLD_H, on `send_resp`:
  - If `mv_indx` == NUM_MOVES-1 -> IDLE.
  - Else `mv_indx`++ -> VERT.
- Headings (`cmd[11:4]`): north 8'h00, west 8'h3F, south 8'h7F, east 8'hBF. Squares are in `cmd[3:0]`.
- Move decode (dx, dy). Vertical leg = |dy| squares, N if dy>0, else S. Horizontal leg = |dx| squares, E if dx>0, else W.
  - bit0 (+1,+2), bit1 (-1,+2), bit2 (-2,+1), bit3 (-2,-1)
  - bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1)
- Invalid move encodings:
  - Multiple bits set: the lowest set bit wins.
  - `move` == 0 in VERT: go to IDLE immediately and set `cmd_rdy` = 0. No command is issued.
- `resp`:
  - 8'hA5 in IDLE.
  - 8'hA5 in HOLD_H when `mv_indx` == NUM_MOVES-1.
  - 8'h5A otherwise.
- Ignored inputs:
  - `start_tour` outside IDLE.
  - `send_resp` in VERT/HORZ (no HOLD transition until `clr_cmd_rdy`).
  - `clr_cmd_rdy` in HOLD states.
  - `cmd_rdy_UART` outside IDLE, unless the abort feature is compiled in.

## Timing
- Reset (`rst_n` low at a `clk` edge): state IDLE, `mv_indx` = 0, `cmd_rdy` = `cmd_rdy_UART` (passthrough), `resp` = 8'hA5. Applies mid-tour too; no partial leg is retained.
- `cmd`/`cmd_rdy`/`resp` are Moore decodes of state, `mv_indx` and `move` (plus UART inputs in IDLE).
- Edge to edge:
  - `start_tour` at edge N -> `cmd_rdy` = 1 with the VERT command after edge N.
  - `clr_cmd_rdy` at edge N -> `cmd_rdy` = 0 after edge N.
- `move` must be valid one cycle after `mv_indx` changes. The memory is combinational-read; `mv_indx` changes only on HOLD_H exit.
- `clr_cmd_rdy` and `send_resp` in the same cycle in VERT: only the HOLD_V transition is taken.
- Minimum per move: 4 cycles plus `cmd_proc` latency.

## Configuration
- `KNIGHT_TOUR_ABORT_EN` defined:
  - In any non-IDLE state, `cmd_rdy_UART` with `cmd_UART[15:12]` == 4'hF forces IDLE on the next edge and resets `mv_indx` to 0.
  - The abort command then passes through to `cmd_proc` via the IDLE mux.
- Undefined: UART input is ignored for the whole tour.

## Structure
- Package `knight_pkg`:
  - State enum.
  - Opcodes `OP_MOVE`=4'h2, `OP_MOVE_FAN`=4'h3, `OP_ABORT`=4'hF.
  - Heading constants `HDG_N/W/S/E`.
  - Response constants `RESP_ACK`=8'hA5, `RESP_MID`=8'h5A.
- Sub-module `knight_move_decode`: combinational one-hot `move` -> {`vert_heading`, `vert_sq`, `horz_heading`, `horz_sq`, `valid`}.
- The sequencer keeps the FSM, index counter and mux.

## Test plan
- Idle passthrough: `cmd_UART`=16'h2004, `cmd_rdy_UART`=1 -> `cmd`=16'h2004, `cmd_rdy`=1, `resp`=8'hA5.
- Single move, `move`=8'h01:
  - VERT issues `cmd`=16'h2002; then `clr_cmd_rdy`, `send_resp`.
  - HORZ issues `cmd`=16'h3BF1; `resp`=8'h5A at its `send_resp`; `mv_indx` -> 1.
- Full tour with NUM_MOVES=24 and a known solution:
  - 48 commands issued.
  - Final `resp`=8'hA5.
  - Returns to IDLE; `mv_indx`=0 is not required post-tour, only after reset.
- Boundary cases:
  - `move`=8'h0C -> bit2 decode: `cmd`=16'h2001, then 16'h33F2.
  - `move`=8'h00 -> IDLE, no `cmd_rdy`.
  - `start_tour` during HOLD_V ignored.
- Reset mid-tour: `rst_n`=0 in HOLD_H at `mv_indx`=7 -> IDLE, `mv_indx`=0, passthrough restored next cycle.
- With `KNIGHT_TOUR_ABORT_EN`: `cmd_UART`=16'hF000 valid during HORZ -> IDLE next edge, `cmd`=16'hF000 passed through. Without the macro: ignored, tour continues.
